lookup_table_ctrl: RTL

//  Sequencer/owner of one LookupTable unit (DATA_W/ADDR_W, 2-cycle lookup latency).

---
 rtl/lookup_table_ctrl_pkg.sv | 18 +
 rtl/lut_rsp_pipe.sv | 34 +++
 rtl/lookup_table_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lookup_table_ctrl_pkg.sv
// Shared definitions for the LookupTable controller.
//   state_t : controller FSM states (IDLE must encode as 0 so reset drives
//             every state-derived output to 0)
//   ST_W    : width of the state encoding
//   LUT_LAT : LookupTable lookup latency in cycles (in0/in1 -> out0/out1)
package lookup_table_ctrl_pkg;

  localparam int ST_W    = 2;
  localparam int LUT_LAT = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_READY = 2'd3
  } state_t;

endpackage

// File: rtl/lut_rsp_pipe.sv
// Response-valid pipeline: a LAT-deep shift register of "lookup accepted"
// flags, so that out_valid rises exactly LAT cycles after in_valid, in step
// with the LookupTable out0/out1 registers.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears the pipe)
//   in_valid  : lookup accepted this cycle
//   out_valid : LUT outputs hold the response of the lookup from LAT cycles ago
module lut_rsp_pipe
  import lookup_table_ctrl_pkg::*;
#(
  parameter int LAT = LUT_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);

  logic [LAT-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign out_valid = sr_q[LAT-1];

endmodule

// File: rtl/lookup_table_ctrl.sv
// Sequencer/owner of one LookupTable unit. Bulk-loads the table from a
// valid/ready stream through the LUT databus port, then grants lookups and
// tags each response with rsp_valid aligned to the LUT output latency.
// Lookups are only granted in READY, so the LUT's port-A address hijack during
// its write cycle (which always falls in WAIT) never meets a live lookup.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   cfg_start/base/len/abort    : load control (len 0..2**ADDR_W)
//   s_valid/s_data/s_ready      : load word stream
//   lut_valid/wstrb/addr/wdata  : LUT databus write, acked by lut_ready
//   lut_run                     : LUT run enable (high in READY)
//   req_valid/addr0/addr1/ready : lookup requests
//   lut_in0/lut_in1             : zero-extended lookup addresses to the LUT
//   rsp_valid                   : LUT out0/out1 hold a response
//   busy/loaded/err             : status; err is sticky until an accepted start
//   state_dbg                   : current FSM state
//
// Handshakes: a transfer happens on a cycle where valid && ready are both high
// at the rising clock edge; valid never depends on ready. s_ready and
// req_ready are combinational from state and the control pulses (cfg_abort
// blocks s_ready, cfg_start blocks req_ready).
module lookup_table_ctrl
  import lookup_table_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int RDY_TO = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W:0]     cfg_len,
  input  logic                cfg_abort,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  output logic                s_ready,
  output logic                lut_valid,
  output logic [DATA_W/8-1:0] lut_wstrb,
  output logic [ADDR_W-1:0]   lut_addr,
  output logic [DATA_W-1:0]   lut_wdata,
  input  logic                lut_ready,
  output logic                lut_run,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr0,
  input  logic [ADDR_W-1:0]   req_addr1,
  output logic                req_ready,
  output logic [DATA_W-1:0]   lut_in0,
  output logic [DATA_W-1:0]   lut_in1,
  output logic                rsp_valid,
  output logic                busy,
  output logic                loaded,
  output logic                err,
  output state_t              state_dbg
);

  localparam int TO_W = $clog2(RDY_TO + 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [ADDR_W:0]   idx_inc;

  assign idx_inc = idx_q + (ADDR_W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      base_q   <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      base_q   <= base_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    base_d    = base_q;
    loaded_d  = loaded_q;
    err_d     = err_q;
    abort_d   = abort_q;
    to_cnt_d  = to_cnt_q;
    s_ready   = 1'b0;
    lut_valid = 1'b0;
    req_ready = 1'b0;

    case (state_q)
      ST_IDLE, ST_READY: begin
        // cfg_start outranks lookups even when its length is rejected
        req_ready = (state_q == ST_READY) && !cfg_start;
        if (cfg_start) begin
          if (cfg_len > DEPTH) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            base_d  = cfg_base;
            len_d   = cfg_len;
            idx_d   = '0;
            abort_d = 1'b0;
            if (cfg_len == '0) begin
              state_d  = ST_READY;
              loaded_d = 1'b1;
            end else begin
              state_d  = ST_LOAD;
              loaded_d = 1'b0;
            end
          end
        end
      end

      ST_LOAD: begin
        if (cfg_abort) begin
          // abort beats a simultaneous stream word: nothing is written
          state_d = ST_IDLE;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            lut_valid = 1'b1;
            state_d   = ST_WAIT;
            to_cnt_d  = '0;
          end
        end
      end

      ST_WAIT: begin
        if (cfg_abort) abort_d = 1'b1;
        if (lut_ready) begin
          idx_d = idx_inc;
          if (abort_q || cfg_abort) begin
            state_d  = ST_IDLE;
            loaded_d = 1'b0;
            abort_d  = 1'b0;
          end else if (idx_inc == len_q) begin
            state_d  = ST_READY;
            loaded_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else if (to_cnt_q == TO_W'(RDY_TO - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          abort_d = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Write address wraps modulo the table depth by truncation.
  assign lut_addr  = lut_valid ? (base_q + idx_q[ADDR_W-1:0]) : '0;
  assign lut_wdata = lut_valid ? s_data : '0;
  assign lut_wstrb = {(DATA_W/8){lut_valid}};

  assign lut_in0   = DATA_W'(req_addr0);
  assign lut_in1   = DATA_W'(req_addr1);
  assign lut_run   = (state_q == ST_READY);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_WAIT);
  assign loaded    = loaded_q;
  assign err       = err_q;
  assign state_dbg = state_q;

  lut_rsp_pipe #(.LAT(LUT_LAT)) u_rsp_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (req_valid && req_ready),
    .out_valid(rsp_valid)
  );

endmodule
